// File: rtl/matmul_operand_feeder.sv
// -----------------------------------------------------------------------------
// matmul_operand_feeder
//
// Producer side of a 3x3 MAC-array multiplier. Collects operand matrices W and
// X as three valid/ready beats (beat k = W column k and X row k), then drives
// the array with one clear cycle followed by three load cycles carrying the
// outer-product terms W[:,k] x X[k,:]. After the last load the array settles
// for MAC_LAT cycles, and then done pulses for one cycle.
//
// Optional feature (macro MATMUL_FEED_ACC_EN): adds the acc_mode input,
// sampled on the first beat of a product. When it is set, the clear cycle is
// skipped, so results accumulate onto the current array contents.
//
// Parameters:
//   DW       operand element width (unsigned)
//   MAC_LAT  settle cycles between the last load and done (0..15)
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand beat handshake (in_ready is combinational)
//   in_w                  {W[2][k],W[1][k],W[0][k]} for beat k
//   in_x                  {X[k][2],X[k][1],X[k][0]} for beat k
//   flush                 synchronous abort
//   acc_mode              (MATMUL_FEED_ACC_EN only) skip clear for this product
//   data_w1..3, data_x1..3  registered operands to the MAC array
//   load, clear           registered MAC accumulate enable / accumulator clear
//   busy                  high outside IDLE and FILL
//   done                  one-cycle pulse when results are valid in the array
//
// States:
//   state    | meaning
//   S_IDLE   | waiting for the first beat
//   S_FILL   | beats 1..2 outstanding, gaps allowed
//   S_CLEAR  | clear pulse to the array
//   S_FEED   | three load cycles, feed_idx selects the buffered beat
//   S_SETTLE | waiting MAC_LAT cycles for the array pipeline
//   S_DONE   | done pulse
//   S_SCRUB  | clear pulse after a flush that interrupted array activity
// -----------------------------------------------------------------------------
module matmul_operand_feeder #(
  parameter int DW      = 4,
  parameter int MAC_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3*DW-1:0] in_w,
  input  logic [3*DW-1:0] in_x,
  input  logic          flush,
`ifdef MATMUL_FEED_ACC_EN
  input  logic          acc_mode,
`endif
  output logic [DW-1:0] data_w1,
  output logic [DW-1:0] data_w2,
  output logic [DW-1:0] data_w3,
  output logic [DW-1:0] data_x1,
  output logic [DW-1:0] data_x2,
  output logic [DW-1:0] data_x3,
  output logic          load,
  output logic          clear,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_CLEAR,
    S_FEED,
    S_SETTLE,
    S_DONE,
    S_SCRUB
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = (MAC_LAT > 0) ? 4'(MAC_LAT - 1) : 4'd0;

  state_t              state;
  logic [1:0]          beat_cnt;
  logic [1:0]          feed_idx;
  logic [3:0]          settle_cnt;
  logic [6*DW-1:0]     bus;
  logic [3*DW-1:0]     w_buf [0:2];
  logic [3*DW-1:0]     x_buf [0:2];
  logic [6*DW-1:0]     feed_word [0:2];
  logic                beat;
  logic                skip_clear;

  assign in_ready = ((state == S_IDLE) || (state == S_FILL)) && !flush;
  assign beat     = in_valid && in_ready;

  assign {data_w1, data_w2, data_w3, data_x1, data_x2, data_x3} = bus;

  // Reorder a buffered beat into bus order: data_wi = W[i-1][k], data_xj = X[k][j-1].
  for (genvar k = 0; k < 3; k++) begin : g_feed_word
    assign feed_word[k] = {w_buf[k][DW-1:0], w_buf[k][2*DW-1:DW], w_buf[k][3*DW-1:2*DW],
                           x_buf[k][DW-1:0], x_buf[k][2*DW-1:DW], x_buf[k][3*DW-1:2*DW]};
  end

  // beat_cnt is 0 in IDLE, so it addresses the slot directly in both IDLE and FILL.
  always_ff @(posedge clk) begin
    if (beat) begin
      w_buf[beat_cnt] <= in_w;
      x_buf[beat_cnt] <= in_x;
    end
  end

`ifdef MATMUL_FEED_ACC_EN
  logic acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 1'b0;
    end else if (beat && (state == S_IDLE)) begin
      acc_q <= acc_mode;
    end
  end

  assign skip_clear = acc_q;
`else
  assign skip_clear = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      beat_cnt   <= 2'd0;
      feed_idx   <= 2'd0;
      settle_cnt <= 4'd0;
      bus        <= '0;
      load       <= 1'b0;
      clear      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      // Outputs default to an idle bus; each transition sets what the next state shows.
      bus   <= '0;
      load  <= 1'b0;
      clear <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b1;

      case (state)
        S_IDLE: begin
          busy <= 1'b0;
          if (beat) begin
            beat_cnt <= 2'd1;
            state    <= S_FILL;
          end
        end

        S_FILL: begin
          busy <= 1'b0;
          if (flush) begin
            beat_cnt <= 2'd0;
            state    <= S_IDLE;
          end else if (beat) begin
            if (beat_cnt == 2'd2) begin
              beat_cnt <= 2'd0;
              busy     <= 1'b1;
              if (skip_clear) begin
                // Slot 0 was written on an earlier beat, so it is safe to present now.
                feed_idx <= 2'd0;
                load     <= 1'b1;
                bus      <= feed_word[0];
                state    <= S_FEED;
              end else begin
                clear <= 1'b1;
                state <= S_CLEAR;
              end
            end else begin
              beat_cnt <= beat_cnt + 2'd1;
            end
          end
        end

        S_CLEAR: begin
          if (flush) begin
            clear <= 1'b1;
            state <= S_SCRUB;
          end else begin
            feed_idx <= 2'd0;
            load     <= 1'b1;
            bus      <= feed_word[0];
            state    <= S_FEED;
          end
        end

        S_FEED: begin
          if (flush) begin
            clear <= 1'b1;
            state <= S_SCRUB;
          end else if (feed_idx == 2'd2) begin
            if (MAC_LAT == 0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              settle_cnt <= SETTLE_LOAD;
              state      <= S_SETTLE;
            end
          end else begin
            feed_idx <= feed_idx + 2'd1;
            load     <= 1'b1;
            bus      <= feed_word[feed_idx + 2'd1];
          end
        end

        S_SETTLE: begin
          if (flush) begin
            clear <= 1'b1;
            state <= S_SCRUB;
          end else if (settle_cnt == 4'd0) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end

        // Results are already in the array, so a flush here changes nothing.
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        S_SCRUB: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy     <= 1'b0;
          beat_cnt <= 2'd0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_operand_feeder.sv
module tb_matmul_operand_feeder;

  localparam int DW      = 4;
  localparam int MAC_LAT = 1;

  logic            clk      = 1'b0;
  logic            rst_n    = 1'b1;
  logic            in_valid = 1'b0;
  logic            flush    = 1'b0;
  logic            acc_mode = 1'b0;
  logic [3*DW-1:0] in_w     = '0;
  logic [3*DW-1:0] in_x     = '0;
  logic            in_ready;
  logic [DW-1:0]   data_w1, data_w2, data_w3, data_x1, data_x2, data_x3;
  logic            load, clear, busy, done;

  always #5 clk = ~clk;

  matmul_operand_feeder #(.DW(DW), .MAC_LAT(MAC_LAT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_w     (in_w),
    .in_x     (in_x),
    .flush    (flush),
`ifdef MATMUL_FEED_ACC_EN
    .acc_mode (acc_mode),
`endif
    .data_w1  (data_w1),
    .data_w2  (data_w2),
    .data_w3  (data_w3),
    .data_x1  (data_x1),
    .data_x2  (data_x2),
    .data_x3  (data_x3),
    .load     (load),
    .clear    (clear),
    .busy     (busy),
    .done     (done)
  );

  int checks   = 0;
  int failures = 0;

  logic [6*DW-1:0] feed_q[$];
  logic [89:0]     res_q[$];

  int          wm[3][3];
  int          xm[3][3];
  int          exp_c[3][3];
  logic [9:0]  macc[3][3];
  logic [6*DW-1:0] mon_bus;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3*DW-1:0] col_w(input int k);
    return {DW'(wm[2][k]), DW'(wm[1][k]), DW'(wm[0][k])};
  endfunction

  function automatic logic [3*DW-1:0] row_x(input int k);
    return {DW'(xm[k][2]), DW'(xm[k][1]), DW'(xm[k][0])};
  endfunction

  function automatic logic [6*DW-1:0] feed_exp(input int k);
    return {DW'(wm[0][k]), DW'(wm[1][k]), DW'(wm[2][k]),
            DW'(xm[k][0]), DW'(xm[k][1]), DW'(xm[k][2])};
  endfunction

  function automatic logic [89:0] pack_macc();
    logic [89:0] p;
    p = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[(i*3+j)*10 +: 10] = macc[i][j];
    return p;
  endfunction

  function automatic logic [89:0] pack_exp();
    logic [89:0] p;
    p = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[(i*3+j)*10 +: 10] = 10'(exp_c[i][j]);
    return p;
  endfunction

  // Array model plus per-cycle bus checks; consumes the scoreboard queues.
  always @(negedge clk) begin
    mon_bus = {data_w1, data_w2, data_w3, data_x1, data_x2, data_x3};
    if (load !== 1'b1) begin
      chk("idle_bus_zero", mon_bus, '0);
    end else if (feed_q.size() == 0) begin
      chk("load_unexpected", 1, 0);
    end else begin
      chk("feed_data", mon_bus, feed_q.pop_front());
    end
    chk("clear_load_excl", clear & load, 0);
    if (clear === 1'b1) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          macc[i][j] = '0;
    end else if (load === 1'b1) begin
      macc[0][0] = macc[0][0] + 10'(data_w1 * data_x1);
      macc[0][1] = macc[0][1] + 10'(data_w1 * data_x2);
      macc[0][2] = macc[0][2] + 10'(data_w1 * data_x3);
      macc[1][0] = macc[1][0] + 10'(data_w2 * data_x1);
      macc[1][1] = macc[1][1] + 10'(data_w2 * data_x2);
      macc[1][2] = macc[1][2] + 10'(data_w2 * data_x3);
      macc[2][0] = macc[2][0] + 10'(data_w3 * data_x1);
      macc[2][1] = macc[2][1] + 10'(data_w3 * data_x2);
      macc[2][2] = macc[2][2] + 10'(data_w3 * data_x3);
    end
    if (done === 1'b1) begin
      if (res_q.size() == 0) chk("done_unexpected", 1, 0);
      else                   chk("result", pack_macc(), res_q.pop_front());
    end
  end

  // Called and returns at posedge+1.
  task automatic send_beat(input logic [3*DW-1:0] w, input logic [3*DW-1:0] x, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      chk("gap_stays_fill", {in_ready, busy, clear, load}, 4'b1000);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_w     = w;
    in_x     = x;
    n        = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("beat_accept_in_time", n < 50, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic start_product(input bit acc, input int g0, input int g1, input int g2,
                               input bit skip0);
    int s;
    for (int k = 0; k < 3; k++) feed_q.push_back(feed_exp(k));
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        s = 0;
        for (int k = 0; k < 3; k++) s += wm[i][k] * xm[k][j];
        exp_c[i][j] = acc ? exp_c[i][j] + s : s;
      end
    res_q.push_back(pack_exp());
    if (!skip0) begin
      acc_mode = acc;
      send_beat(col_w(0), row_x(0), g0);
      acc_mode = !acc;
    end
    send_beat(col_w(1), row_x(1), g1);
    send_beat(col_w(2), row_x(2), g2);
    acc_mode = 1'b0;
  endtask

  // Cycle-by-cycle control after the third beat; ends at posedge+1 of the IDLE cycle.
  task automatic timeline(input bit acc);
    int f;
    int nlast;
    logic [4:0] e;
    f     = acc ? 1 : 2;
    nlast = f + 3 + MAC_LAT;
    for (int n = 1; n <= nlast; n++) begin
      @(negedge clk);
      e = {(!acc && n == 1), (n >= f && n < f + 3), (n == nlast), 1'b1, 1'b0};
      chk($sformatf("timeline_c%0d", n), {clear, load, done, busy, in_ready}, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic set_const(input int v);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        wm[i][j] = v;
        xm[i][j] = v;
      end
  endtask

  task automatic set_random();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        wm[i][j] = int'($urandom_range(0, 15));
        xm[i][j] = int'($urandom_range(0, 15));
      end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {data_w1, data_w2, data_w3, data_x1, data_x2, data_x3,
                          load, clear, busy, done}, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {in_ready, busy}, 2'b10);
    @(posedge clk); #1;

    // All elements 3, consecutive beats: every accumulator 27.
    set_const(3);
    start_product(0, 0, 0, 0, 0);
    timeline(0);

    // Identity W: data_w walks 100/010/001 and the result equals X.
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        wm[i][j] = (i == j) ? 1 : 0;
        xm[i][j] = i * 3 + j + 1;
      end
    start_product(0, 0, 0, 0, 0);
    timeline(0);

    // Gapped beats, then the next product's first beat held through the busy period.
    set_random();
    start_product(0, 0, 2, 5, 0);
    set_random();
    in_valid = 1'b1;
    in_w     = col_w(0);
    in_x     = row_x(0);
    timeline(0);
    @(negedge clk);
    chk("b2b_ready_after_done", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    start_product(0, 0, 0, 0, 1);
    timeline(0);

    // Flush in FILL discards the partial set; a flushed beat is not taken.
    send_beat(12'hfff, 12'hfff, 0);
    flush    = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    chk("flush_blocks_ready", {in_ready, busy, clear, load}, 4'b0000);
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    set_random();
    start_product(0, 1, 0, 0, 0);
    timeline(0);

    // Flush in the second FEED cycle: one scrub clear, back to IDLE, no done.
    set_random();
    start_product(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("flush_pre_clear", {clear, load}, 2'b10);
    @(posedge clk); #1;
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_cycle", {clear, load, in_ready}, 3'b010);
    @(posedge clk); #1 flush = 1'b0;
    feed_q.delete();
    res_q.delete();
    @(negedge clk);
    chk("flush_scrub", {clear, load, done, busy, in_ready}, 5'b10010);
    @(negedge clk);
    chk("flush_idle", {clear, load, done, busy, in_ready}, 5'b00001);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of FEED.
    set_random();
    start_product(0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("pre_reset_load", load, 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_drop", {data_w1, data_w2, data_w3, data_x1, data_x2, data_x3,
                             load, clear, busy, done}, '0);
    feed_q.delete();
    res_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_mid_reset", {in_ready, busy}, 2'b10);
    @(posedge clk); #1;
    set_random();
    start_product(0, 0, 0, 0, 0);
    timeline(0);

`ifdef MATMUL_FEED_ACC_EN
    // Tiled accumulation: second product skips clear, accumulators reach 24.
    set_const(2);
    start_product(0, 0, 0, 0, 0);
    timeline(0);
    start_product(1, 0, 0, 0, 0);
    timeline(1);
`endif

    repeat (3) @(negedge clk);
    chk("queues_drained", {feed_q.size() == 0, res_q.size() == 0}, 2'b11);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
